reg_file: RTL
=============

Name: reg_file

Overview:
- Architectural register file with rename-status tracking for the Tomasulo core.
- Responder side of the decode-stage register query: decode presents two register tags; this block returns value, ROB tag and busy flag for each.
- Also accepts destination renames from dispatch and value writes from ROB commit, and clears all pending renames on flush.

Parameters:
DATA_W, 32, register data width
REG_TAG_W, 5, register index width (32 registers)
ROB_TAG_W, 4, ROB entry tag width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low
rdy  input  1  global ready; when low, no state changes
in_reg_tag1  input  REG_TAG_W  source register 1 index from decode
out_reg_value1  output  DATA_W  register 1 value
out_reg_robtag1  output  ROB_TAG_W  ROB tag producing register 1
out_reg_busy1  output  1  register 1 awaiting ROB result
in_reg_tag2  input  REG_TAG_W  source register 2 index
out_reg_value2  output  DATA_W  register 2 value
out_reg_robtag2  output  ROB_TAG_W  ROB tag producing register 2
out_reg_busy2  output  1  register 2 awaiting ROB result
in_rename_en  input  1  dispatch renames a destination this cycle
in_rename_reg  input  REG_TAG_W  destination register index
in_rename_robtag  input  ROB_TAG_W  ROB tag assigned to the destination
in_commit_en  input  1  ROB commits a register write this cycle
in_commit_reg  input  REG_TAG_W  committed destination index
in_commit_robtag  input  ROB_TAG_W  ROB tag of the committing entry
in_commit_value  input  DATA_W  committed value
in_flush  input  1  misprediction flush

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous, active-low.
- State per register i (0..31): value[i], robtag[i], busy[i].
- Reset (rst=0): all value, robtag and busy are 0 immediately, independent of clk.
- Read ports are combinational with zero latency. Each reads the registered state, plus a commit bypass:
  - Bypass condition: in_commit_en=1, in_commit_reg==tag, tag!=0, busy[tag]=1 and robtag[tag]==in_commit_robtag.
  - When the bypass condition holds, the port outputs value=in_commit_value and busy=0.
  - Otherwise the port outputs value[tag], robtag[tag] and busy[tag].
  - Same-cycle renames never affect read outputs; sources see the pre-rename mapping.
- Register x0: reads always return value 0, robtag 0, busy 0. Renames and commits targeting x0 are ignored.
- Sequential updates occur only when rdy=1 and rst=1:
  - Commit: value[r] <= in_commit_value. busy[r] <= 0 only if busy[r]=1 and robtag[r]==in_commit_robtag. If a younger rename holds the register, the value is written but busy and robtag are kept.
  - Rename, with in_flush=0: busy[r] <= 1 and robtag[r] <= in_rename_robtag.
  - Commit and rename to the same register in the same cycle: the value is written, busy=1 and robtag = new rename tag (rename wins).
  - Flush: every busy bit <= 0 on that edge. A commit in the same cycle still writes its value. A rename in the same cycle is dropped.
- rdy=0: all state is held and read ports remain live.
- Reset asserted mid-operation clears state immediately; pending renames and commits are lost.
- Arithmetic: none beyond equality compares. Tags are unsigned and no wrap handling is needed.

Test Plan:
- Reset release: read x5/x31 -> value 0, busy 0, robtag 0. Pulse rst low after writes -> all zero without a clock edge.
- Rename x3 with tag 7; next cycle read x3 -> busy 1, robtag 7. Commit x3 tag 7 value 0xDEADBEEF -> same-cycle read returns 0xDEADBEEF with busy 0; next cycle value 0xDEADBEEF, busy 0.
- Rename x4 tag 2, then rename x4 tag 5. Commit x4 tag 2 value 0x11 -> value 0x11, busy stays 1, robtag 5. Commit tag 5 value 0x22 -> busy 0, value 0x22.
- Same cycle: commit x6 tag 1 value 0x33 (x6 busy with tag 1) and rename x6 tag 9 -> next cycle value 0x33, busy 1, robtag 9. Same-cycle read of x6 shows the bypass value 0x33 with busy 0.
- Registers x1, x2 and x8 busy; assert in_flush together with rename x10 tag 3 and commit x8 value 0x44 -> all busy 0, x10 not busy, x8 value 0x44.
- Rename/commit x0 with value 0x55 -> x0 reads 0, not busy. rdy=0 during a rename of x7 -> x7 unchanged.

Source files
------------

// File: rtl/reg_file.sv
// Architectural register file with per-register rename status (ROB tag + busy).
// Two combinational read ports with commit bypass; rename, commit and flush update state.
module reg_file #(
  parameter int DATA_W    = 32,
  parameter int REG_TAG_W = 5,
  parameter int ROB_TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic [REG_TAG_W-1:0] in_reg_tag1,
  output logic [DATA_W-1:0]    out_reg_value1,
  output logic [ROB_TAG_W-1:0] out_reg_robtag1,
  output logic                 out_reg_busy1,
  input  logic [REG_TAG_W-1:0] in_reg_tag2,
  output logic [DATA_W-1:0]    out_reg_value2,
  output logic [ROB_TAG_W-1:0] out_reg_robtag2,
  output logic                 out_reg_busy2,
  input  logic                 in_rename_en,
  input  logic [REG_TAG_W-1:0] in_rename_reg,
  input  logic [ROB_TAG_W-1:0] in_rename_robtag,
  input  logic                 in_commit_en,
  input  logic [REG_TAG_W-1:0] in_commit_reg,
  input  logic [ROB_TAG_W-1:0] in_commit_robtag,
  input  logic [DATA_W-1:0]    in_commit_value,
  input  logic                 in_flush
);

  localparam int NREG = 1 << REG_TAG_W;

  logic [DATA_W-1:0]    value_q  [NREG];
  logic [DATA_W-1:0]    value_d  [NREG];
  logic [ROB_TAG_W-1:0] robtag_q [NREG];
  logic [ROB_TAG_W-1:0] robtag_d [NREG];
  logic [NREG-1:0]      busy_q;
  logic [NREG-1:0]      busy_d;

  logic commit_ok;
  logic rename_ok;
  logic hit1;
  logic hit2;

  assign commit_ok = in_commit_en && (in_commit_reg != '0);
  assign rename_ok = in_rename_en && (in_rename_reg != '0) && !in_flush;

  // Rename is applied last so it wins over a same-cycle commit to the same register.
  always_comb begin
    value_d  = value_q;
    robtag_d = robtag_q;
    busy_d   = busy_q;
    if (rdy) begin
      if (in_flush) busy_d = '0;
      if (commit_ok) begin
        value_d[in_commit_reg] = in_commit_value;
        if (busy_q[in_commit_reg] && (robtag_q[in_commit_reg] == in_commit_robtag))
          busy_d[in_commit_reg] = 1'b0;
      end
      if (rename_ok) begin
        busy_d[in_rename_reg]   = 1'b1;
        robtag_d[in_rename_reg] = in_rename_robtag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        value_q[i]  <= '0;
        robtag_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      value_q  <= value_d;
      robtag_q <= robtag_d;
      busy_q   <= busy_d;
    end
  end

  // A commit that retires the producer a source is waiting on is forwarded in the same cycle.
  assign hit1 = commit_ok && (in_commit_reg == in_reg_tag1) && busy_q[in_reg_tag1] &&
                (robtag_q[in_reg_tag1] == in_commit_robtag);
  assign hit2 = commit_ok && (in_commit_reg == in_reg_tag2) && busy_q[in_reg_tag2] &&
                (robtag_q[in_reg_tag2] == in_commit_robtag);

  always_comb begin
    out_reg_value1  = '0;
    out_reg_robtag1 = '0;
    out_reg_busy1   = 1'b0;
    if (in_reg_tag1 != '0) begin
      out_reg_value1  = hit1 ? in_commit_value : value_q[in_reg_tag1];
      out_reg_robtag1 = robtag_q[in_reg_tag1];
      out_reg_busy1   = hit1 ? 1'b0 : busy_q[in_reg_tag1];
    end
  end

  always_comb begin
    out_reg_value2  = '0;
    out_reg_robtag2 = '0;
    out_reg_busy2   = 1'b0;
    if (in_reg_tag2 != '0) begin
      out_reg_value2  = hit2 ? in_commit_value : value_q[in_reg_tag2];
      out_reg_robtag2 = robtag_q[in_reg_tag2];
      out_reg_busy2   = hit2 ? 1'b0 : busy_q[in_reg_tag2];
    end
  end

endmodule
